// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encoding,
// default memory depth, frame constants and the frame length check.
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CHK    = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam int DEFAULT_DEPTH = 64;
    localparam int LEN_BYTES     = 2;
    localparam int WORD_BYTES    = 4;

    // A frame is only usable if it carries at least one word and fits in memory.
    function automatic logic len_ok(input logic [15:0] n, input int depth);
        return (n != 16'd0) && (32'(n) <= depth);
    endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs four consecutive bytes into a little-endian 32-bit word; word_valid
// pulses combinationally with the fourth byte so the caller can register it.
module program_loader_byte_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_cnt;
    logic [23:0] low_bytes;

    always_ff @(posedge clk) begin
        if (clear) begin
            byte_cnt  <= 2'd0;
            low_bytes <= 24'd0;
        end else if (byte_valid) begin
            byte_cnt  <= byte_cnt + 2'd1;
            low_bytes <= {byte_data, low_bytes[23:8]};
        end
    end

    // After three shifts low_bytes holds {b2, b1, b0}; the live byte is b3.
    assign word       = {byte_data, low_bytes};
    assign word_valid = byte_valid && (byte_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length/payload/checksum byte frame, writes words into
// instruction memory and releases the core once the image checks out.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    state_t      state, state_nxt;
    logic [7:0]  len_lo;
    logic [15:0] len_words;
    logic [15:0] word_cnt;
    logic [7:0]  chk_sum;
    logic [15:0] rx_len;
    logic        accept;
    logic [31:0] asm_word;
    logic        asm_valid;

    assign in_ready = !reset && !reload &&
                      ((state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA)   || (state == S_CHK));
    assign accept   = in_valid && in_ready;
    assign rx_len   = {in_data, len_lo};

    program_loader_byte_assembler u_asm (
        .clk        (clk),
        .clear      (reset || reload),
        .byte_valid (accept && (state == S_DATA)),
        .byte_data  (in_data),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_LEN_LO;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        core_reset = (state != S_DONE);
        done       = (state == S_DONE);
        error      = (state == S_ERROR);
        if (reload) begin
            state_nxt = S_LEN_LO;
        end else if (accept) begin
            case (state)
                S_LEN_LO: state_nxt = S_LEN_HI;
                S_LEN_HI: state_nxt = len_ok(rx_len, DEPTH) ? S_DATA : S_ERROR;
                S_DATA:   if (asm_valid && (word_cnt + 16'd1 == len_words)) state_nxt = S_CHK;
                S_CHK:    state_nxt = (in_data == chk_sum) ? S_DONE : S_ERROR;
                default:  state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_lo     <= 8'd0;
            len_words  <= 16'd0;
            word_cnt   <= 16'd0;
            chk_sum    <= 8'd0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= 32'd0;
        end else if (reload) begin
            // Memory contents and the last write address/data are left alone.
            len_lo    <= 8'd0;
            len_words <= 16'd0;
            word_cnt  <= 16'd0;
            chk_sum   <= 8'd0;
            imem_we   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                case (state)
                    S_LEN_LO: len_lo    <= in_data;
                    S_LEN_HI: len_words <= rx_len;
                    S_DATA: begin
                        chk_sum <= chk_sum + in_data;
                        if (asm_valid) begin
                            imem_we    <= 1'b1;
                            imem_waddr <= word_cnt[ADDR_W-1:0];
                            imem_wdata <= asm_word;
                            word_cnt   <= word_cnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign words_loaded = word_cnt;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus randomized
// frames checked against a byte-level model of the framing rules.
module tb_program_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;
    logic [15:0]       words_loaded;

    program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic [7:0]        frame[$];
    logic [31:0]       exp_words[$];

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_waddr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    // All tasks start and end one time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int max_idle, output bit ok);
        int idle;
        idle = (max_idle > 0) ? int'($urandom_range(max_idle, 1)) : 0;
        ok = 1'b0;
        in_valid = 1'b0;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int first, input int last, input int max_idle);
        bit ok;
        for (int i = first; i <= last; i++) begin
            send_byte(frame[i], max_idle, ok);
            if (!ok) begin
                total++;
                $display("FAIL byte_accept_timeout: byte %0d not accepted, in_ready=%b want 1", i, in_ready);
                return;
            end
        end
    endtask

    task automatic do_reload;
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Reference model: frame bytes and the words the loader must write.
    task automatic build_frame(input int n, input bit corrupt);
        int sum;
        logic [7:0] b;
        logic [31:0] w;
        frame.delete();
        exp_words.delete();
        frame.push_back(8'(n % 256));
        frame.push_back(8'(n / 256));
        sum = 0;
        for (int i = 0; i < n; i++) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++) begin
                b = 8'($urandom_range(255, 0));
                frame.push_back(b);
                sum = sum + int'(b);
                w = w + (32'(b) << (8 * k));
            end
            exp_words.push_back(w);
        end
        sum = sum % 256;
        if (corrupt) sum = (sum + int'($urandom_range(255, 1))) % 256;
        frame.push_back(8'(sum));
    endtask

    task automatic load_nominal_frame;
        frame.delete();
        frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'ha0, 8'h00, 8'h93, 8'h05, 8'h40, 8'h01, 8'h91};
    endtask

    task automatic check_nominal_writes(input string tag);
        total++;
        if (wr_addr_q.size() != 2) begin
            $display("FAIL %s_write_count: got %0d want 2", tag, wr_addr_q.size());
            return;
        end
        passed++;
        total++;
        if (wr_addr_q[0] !== 6'd0 || wr_data_q[0] !== 32'h00a00513)
            $display("FAIL %s_write0: got %0d/%h want 0/00a00513", tag, wr_addr_q[0], wr_data_q[0]);
        else passed++;
        total++;
        if (wr_addr_q[1] !== 6'd1 || wr_data_q[1] !== 32'h01400593)
            $display("FAIL %s_write1: got %0d/%h want 1/01400593", tag, wr_addr_q[1], wr_data_q[1]);
        else passed++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h02;
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready_during: got %b want 0", in_ready);
        else passed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({in_ready, imem_we, core_reset, done, error} !== 5'b10100)
            $display("FAIL reset_flags: got ready/we/core_reset/done/error=%b want 10100",
                     {in_ready, imem_we, core_reset, done, error});
        else passed++;
        total++;
        if (imem_waddr !== '0 || imem_wdata !== 32'd0 || words_loaded !== 16'd0)
            $display("FAIL reset_values: got waddr=%0d wdata=%h words=%0d want 0/0/0",
                     imem_waddr, imem_wdata, words_loaded);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_nominal(input string tag, input int max_idle);
        load_nominal_frame();
        send_frame(0, 9, max_idle);
        @(negedge clk);
        total++;
        if (done !== 1'b0 || core_reset !== 1'b1)
            $display("FAIL %s_done_early: got done=%b core_reset=%b want 0/1", tag, done, core_reset);
        else passed++;
        @(posedge clk);
        #1;
        send_frame(10, 10, max_idle);
        @(negedge clk);
        total++;
        if (done !== 1'b1 || core_reset !== 1'b0 || error !== 1'b0)
            $display("FAIL %s_done_timing: got done=%b core_reset=%b error=%b want 1/0/0",
                     tag, done, core_reset, error);
        else passed++;
        total++;
        if (words_loaded !== 16'd2 || in_ready !== 1'b0)
            $display("FAIL %s_words_ready: got words=%0d in_ready=%b want 2/0", tag, words_loaded, in_ready);
        else passed++;
        check_nominal_writes(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic test_bad_checksum;
        do_reload();
        load_nominal_frame();
        frame[10] = 8'h90;
        send_frame(0, 10, 0);
        @(negedge clk);
        total++;
        if ({error, done, core_reset, in_ready} !== 4'b1010)
            $display("FAIL badchk_flags: got error/done/core_reset/in_ready=%b want 1010",
                     {error, done, core_reset, in_ready});
        else passed++;
        check_nominal_writes("badchk");
        @(posedge clk);
        #1;
    endtask

    task automatic test_bad_length;
        for (int t = 0; t < 2; t++) begin
            do_reload();
            frame.delete();
            frame.push_back((t == 0) ? 8'h00 : 8'h41);
            frame.push_back(8'h00);
            send_frame(0, 1, 0);
            @(negedge clk);
            total++;
            if ({error, done, core_reset, in_ready} !== 4'b1010)
                $display("FAIL badlen%0d_flags: got error/done/core_reset/in_ready=%b want 1010",
                         t, {error, done, core_reset, in_ready});
            else passed++;
            repeat (3) @(posedge clk);
            #1;
            total++;
            if (wr_addr_q.size() != 0 || words_loaded !== 16'd0)
                $display("FAIL badlen%0d_writes: got writes=%0d words=%0d want 0/0",
                         t, wr_addr_q.size(), words_loaded);
            else passed++;
        end
    endtask

    task automatic test_reload_mid;
        do_reload();
        load_nominal_frame();
        send_frame(0, 4, 0);
        reload = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h93;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || core_reset !== 1'b1)
            $display("FAIL reload_cycle: got in_ready=%b core_reset=%b want 0/1", in_ready, core_reset);
        else passed++;
        @(posedge clk);
        #1;
        reload = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (wr_addr_q.size() != 0 || words_loaded !== 16'd0 || in_ready !== 1'b1 || done !== 1'b0)
            $display("FAIL reload_after: got writes=%0d words=%0d in_ready=%b done=%b want 0/0/1/0",
                     wr_addr_q.size(), words_loaded, in_ready, done);
        else passed++;
        @(posedge clk);
        #1;
        test_nominal("after_reload", 0);
    endtask

    task automatic test_reset_in_done;
        total++;
        if (done !== 1'b1) $display("FAIL rst_done_precond: got done=%b want 1", done);
        else passed++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({core_reset, done, in_ready} !== 3'b101 || words_loaded !== 16'd0)
            $display("FAIL rst_done: got core_reset/done/in_ready=%b words=%0d want 101/0",
                     {core_reset, done, in_ready}, words_loaded);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random_frames;
        int n;
        bit corrupt;
        for (int it = 0; it < 6; it++) begin
            n = (it == 0) ? DEPTH : int'($urandom_range(8, 1));
            corrupt = (it == 0) ? 1'b0 : 1'($urandom_range(1, 0));
            do_reload();
            build_frame(n, corrupt);
            send_frame(0, frame.size() - 1, (it % 2 == 1) ? 2 : 0);
            @(negedge clk);
            total++;
            if (done !== !corrupt || error !== corrupt || core_reset !== corrupt)
                $display("FAIL rand%0d_status: got done=%b error=%b core_reset=%b want %b/%b/%b",
                         it, done, error, core_reset, !corrupt, corrupt, corrupt);
            else passed++;
            total++;
            if (words_loaded !== 16'(n) || wr_addr_q.size() != n)
                $display("FAIL rand%0d_count: got words=%0d writes=%0d want %0d", it,
                         words_loaded, wr_addr_q.size(), n);
            else begin
                passed++;
                for (int i = 0; i < n; i++) begin
                    total++;
                    if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_words[i])
                        $display("FAIL rand%0d_write%0d: got %0d/%h want %0d/%h", it, i,
                                 wr_addr_q[i], wr_data_q[i], i, exp_words[i]);
                    else passed++;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        reload = 1'b0;
        test_reset();
        test_nominal("nominal", 0);
        test_bad_checksum();
        test_bad_length();
        do_reload();
        test_nominal("throttled", 3);
        test_reload_mid();
        test_reset_in_done();
        test_random_frames();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
